// File: rtl/hdmi_packet_pkg.sv
// Shared definitions for the HDMI data-island packet scheduler.
// - Packet type codes placed on the packet_type output.
// - packet_sub_t: four 56-bit subpackets as one packed array.
// - sel_e: internal selection result of the priority arbiter.
package hdmi_packet_pkg;

    localparam logic [7:0] PKT_NULL  = 8'h00;
    localparam logic [7:0] PKT_ACR   = 8'h01;
    localparam logic [7:0] PKT_AUDIO = 8'h02;
    localparam logic [7:0] PKT_AVI   = 8'h82;
    localparam logic [7:0] PKT_AINFO = 8'h84;

    typedef logic [3:0][55:0] packet_sub_t;

    // SEL_NONE marks cycles without a packet slot, so nothing is consumed.
    typedef enum logic [2:0] {
        SEL_NONE  = 3'd0,
        SEL_ACR   = 3'd1,
        SEL_AUDIO = 3'd2,
        SEL_AVI   = 3'd3,
        SEL_AINFO = 3'd4,
        SEL_NULL  = 3'd5
    } sel_e;

    // Maps an arbiter selection to the packet type code sent downstream.
    function automatic logic [7:0] type_of_sel(input sel_e sel);
        logic [7:0] code;
        case (sel)
            SEL_ACR:   code = PKT_ACR;
            SEL_AUDIO: code = PKT_AUDIO;
            SEL_AVI:   code = PKT_AVI;
            SEL_AINFO: code = PKT_AINFO;
            default:   code = PKT_NULL;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/hdmi_packet_scheduler.sv
// HDMI data-island packet scheduler (clk_pixel domain).
// Once per packet slot (packet_enable pulse) it picks one packet by fixed
// priority: ACR > audio sample > AVI InfoFrame > Audio InfoFrame > Null, and
// registers its header/subpackets for the packet assembler.
// Ports:
//   clk_pixel, reset_n            : clock, async active-low reset
//   frame_start                   : re-arms AVI / Audio InfoFrames
//   packet_enable                 : start of a packet slot
//   clk_audio_counter_wrap        : ACR request toggle (each edge = 1 request)
//   acr/audio/avi/ainfo_header,sub: candidate packet contents
//   audio_valid / audio_ready     : audio sample handshake (ready is combinational)
//   header, sub, packet_type      : registered selected packet
//   acr_overrun                   : sticky, ACR request lost while one pending
module hdmi_packet_scheduler
    import hdmi_packet_pkg::*;
#(
    parameter bit SEND_ACR        = 1'b1,
    parameter bit SEND_AVI        = 1'b1,
    parameter bit SEND_AUDIO_INFO = 1'b1
) (
    input  logic        clk_pixel,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic        packet_enable,
    input  logic        clk_audio_counter_wrap,
    input  logic [23:0] acr_header,
    input  packet_sub_t acr_sub,
    input  logic        audio_valid,
    output logic        audio_ready,
    input  logic [23:0] audio_header,
    input  packet_sub_t audio_sub,
    input  logic [23:0] avi_header,
    input  packet_sub_t avi_sub,
    input  logic [23:0] ainfo_header,
    input  packet_sub_t ainfo_sub,
    output logic [23:0] header,
    output packet_sub_t sub,
    output logic [7:0]  packet_type,
    output logic        acr_overrun
);

    logic        wrap_q_r;
    logic        acr_pending_r;
    logic        avi_pending_r;
    logic        ainfo_pending_r;
    logic        acr_overrun_r;
    logic [23:0] header_r;
    packet_sub_t sub_r;
    logic [7:0]  packet_type_r;

    logic        acr_req_s;
    sel_e        sel_s;
    logic [23:0] nxt_header_s;
    packet_sub_t nxt_sub_s;

    // Any edge of the wrap toggle is one ACR request.
    assign acr_req_s = (wrap_q_r ^ clk_audio_counter_wrap) & SEND_ACR;

    // Fixed-priority arbitration on same-cycle state; a same-cycle ACR request wins.
    always_comb begin
        sel_s = SEL_NONE;
        if (packet_enable) begin
            if (acr_pending_r | acr_req_s) begin
                sel_s = SEL_ACR;
            end else if (audio_valid) begin
                sel_s = SEL_AUDIO;
            end else if (avi_pending_r) begin
                sel_s = SEL_AVI;
            end else if (ainfo_pending_r) begin
                sel_s = SEL_AINFO;
            end else begin
                sel_s = SEL_NULL;
            end
        end else begin
            sel_s = SEL_NONE;
        end
    end

    // Content mux for the selected packet; Null and no-slot give all zeros.
    always_comb begin
        nxt_header_s = 24'h0;
        nxt_sub_s    = '0;
        case (sel_s)
            SEL_ACR: begin
                nxt_header_s = acr_header;
                nxt_sub_s    = acr_sub;
            end
            SEL_AUDIO: begin
                nxt_header_s = audio_header;
                nxt_sub_s    = audio_sub;
            end
            SEL_AVI: begin
                nxt_header_s = avi_header;
                nxt_sub_s    = avi_sub;
            end
            SEL_AINFO: begin
                nxt_header_s = ainfo_header;
                nxt_sub_s    = ainfo_sub;
            end
            default: begin
                nxt_header_s = 24'h0;
                nxt_sub_s    = '0;
            end
        endcase
    end

    // The audio source sees ready in the same cycle it is selected.
    assign audio_ready = (sel_s == SEL_AUDIO);

    // Edge capture, pending flags, sticky overrun and registered packet outputs.
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            wrap_q_r        <= 1'b0;
            acr_pending_r   <= 1'b0;
            avi_pending_r   <= SEND_AVI;
            ainfo_pending_r <= SEND_AUDIO_INFO;
            acr_overrun_r   <= 1'b0;
            header_r        <= 24'h0;
            sub_r           <= '0;
            packet_type_r   <= PKT_NULL;
        end else begin
            wrap_q_r <= clk_audio_counter_wrap;

            // Consumption absorbs a request arriving in the same cycle.
            if (sel_s == SEL_ACR) begin
                acr_pending_r <= 1'b0;
            end else if (acr_req_s) begin
                acr_pending_r <= 1'b1;
                if (acr_pending_r) begin
                    acr_overrun_r <= 1'b1;
                end
            end

            // Re-arm beats a same-cycle clear so the new frame still gets its InfoFrame.
            if (frame_start && SEND_AVI) begin
                avi_pending_r <= 1'b1;
            end else if (sel_s == SEL_AVI) begin
                avi_pending_r <= 1'b0;
            end

            if (frame_start && SEND_AUDIO_INFO) begin
                ainfo_pending_r <= 1'b1;
            end else if (sel_s == SEL_AINFO) begin
                ainfo_pending_r <= 1'b0;
            end

            if (packet_enable) begin
                header_r      <= nxt_header_s;
                sub_r         <= nxt_sub_s;
                packet_type_r <= type_of_sel(sel_s);
            end
        end
    end

    assign header      = header_r;
    assign sub         = sub_r;
    assign packet_type = packet_type_r;
    assign acr_overrun = acr_overrun_r;

endmodule
